// File: rtl/reg_bank.sv
// -----------------------------------------------------------------------------
// reg_bank
//   Bank of DEPTH registers, WIDTH bits each, with one write port, two
//   independent registered read ports and a sequenced clear-all engine that
//   zeroes one entry per cycle.
//
// Parameters
//   WIDTH  bits per entry (>= 1)
//   DEPTH  number of entries (>= 2, any value; out-of-range addresses are
//          write-dropped and read as zero)
//   AW     address width, $clog2(DEPTH), not overridable
//
// Ports
//   clk, rst_n                  clock, async active-low reset
//   we, waddr, wdata            write port (accepted only while idle)
//   re_a, raddr_a -> rdata_a    registered read port A (holds when re_a=0)
//   re_b, raddr_b -> rdata_b    registered read port B (holds when re_b=0)
//   clr                         start a clear sweep (ignored while busy)
//   busy                        sweep in progress
//   done                        one-cycle pulse after the last entry is swept
//
// Build option
//   REG_BANK_BYPASS_EN  defined   : write-first reads. A read that hits the
//                                   entry written or swept in the same cycle
//                                   returns wdata / zero.
//                       undefined : read-first reads, no forwarding logic.
// -----------------------------------------------------------------------------
module reg_bank #(
    parameter  int WIDTH = 16,
    parameter  int DEPTH = 8,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             we,
    input  logic [AW-1:0]    waddr,
    input  logic [WIDTH-1:0] wdata,
    input  logic             re_a,
    input  logic [AW-1:0]    raddr_a,
    output logic [WIDTH-1:0] rdata_a,
    input  logic             re_b,
    input  logic [AW-1:0]    raddr_b,
    output logic [WIDTH-1:0] rdata_b,
    input  logic             clr,
    output logic             busy,
    output logic             done
);

    // state | meaning
    // ------+-------------------------------------------------------------
    // IDLE  | normal operation; writes accepted, clr starts a sweep
    // CLEAR | sweeping; entry[ptr] zeroed each cycle, writes/clr ignored
    typedef enum logic {
        IDLE  = 1'b0,
        CLEAR = 1'b1
    } state_t;

    localparam logic [AW-1:0] LAST_IDX = AW'(DEPTH - 1);

    state_t           state_q, state_d;
    logic [AW-1:0]    ptr_q, ptr_d;
    logic             done_q, done_d;
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic [WIDTH-1:0] rdata_a_q, rdata_a_d;
    logic [WIDTH-1:0] rdata_b_q, rdata_b_d;

    // Write accepted this cycle: idle and address decodes to a real entry.
    logic             wr_ok;

    always_comb begin
        wr_ok = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            if (we && (state_q == IDLE) && (waddr == AW'(i))) begin
                wr_ok = 1'b1;
            end
        end
    end

    // Address decode by comparison keeps out-of-range reads at zero without
    // indexing past the end of the array when DEPTH is not a power of two.
    function automatic logic [WIDTH-1:0] read_word(input logic [AW-1:0] addr);
        logic [WIDTH-1:0] val;
        val = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (addr == AW'(i)) begin
                val = mem_q[i];
            end
        end
`ifdef REG_BANK_BYPASS_EN
        if (wr_ok && (addr == waddr)) begin
            val = wdata;
        end
        if ((state_q == CLEAR) && (addr == ptr_q)) begin
            val = '0;
        end
`endif
        return val;
    endfunction

    always_comb begin
        rdata_a_d = rdata_a_q;
        rdata_b_d = rdata_b_q;
        if (re_a) begin
            rdata_a_d = read_word(raddr_a);
        end
        if (re_b) begin
            rdata_b_d = read_word(raddr_b);
        end
    end

    // Write and sweep never coincide: writes are only accepted in IDLE.
    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            mem_d[i] = mem_q[i];
            if (wr_ok && (waddr == AW'(i))) begin
                mem_d[i] = wdata;
            end
            if ((state_q == CLEAR) && (ptr_q == AW'(i))) begin
                mem_d[i] = '0;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        done_d  = 1'b0;
        case (state_q)
            IDLE: begin
                if (clr) begin
                    state_d = CLEAR;
                    ptr_d   = '0;
                end
            end
            CLEAR: begin
                if (ptr_q == LAST_IDX) begin
                    state_d = IDLE;
                    ptr_d   = '0;
                    done_d  = 1'b1;
                end else begin
                    ptr_d = ptr_q + AW'(1);
                end
            end
            default: begin
                state_d = IDLE;
                ptr_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            ptr_q     <= '0;
            done_q    <= 1'b0;
            rdata_a_q <= '0;
            rdata_b_q <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            state_q   <= state_d;
            ptr_q     <= ptr_d;
            done_q    <= done_d;
            rdata_a_q <= rdata_a_d;
            rdata_b_q <= rdata_b_d;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= mem_d[i];
            end
        end
    end

    assign rdata_a = rdata_a_q;
    assign rdata_b = rdata_b_q;
    assign busy    = (state_q == CLEAR);
    assign done    = done_q;

endmodule

// File: tb/tb_reg_bank.sv
module tb_reg_bank;

    logic        clk;
    logic        rst_n;

    // DEPTH=8, WIDTH=16 instance
    logic        we, re_a, re_b, clr;
    logic [2:0]  waddr, raddr_a, raddr_b;
    logic [15:0] wdata, rdata_a, rdata_b;
    logic        busy, done;

    // DEPTH=5, WIDTH=8 instance
    logic        we5, re_a5, re_b5, clr5;
    logic [2:0]  waddr5, raddr_a5, raddr_b5;
    logic [7:0]  wdata5, rdata_a5, rdata_b5;
    logic        busy5, done5;

    int n_cmp  = 0;
    int n_fail = 0;

    reg_bank #(.WIDTH(16), .DEPTH(8)) dut (
        .clk(clk), .rst_n(rst_n),
        .we(we), .waddr(waddr), .wdata(wdata),
        .re_a(re_a), .raddr_a(raddr_a), .rdata_a(rdata_a),
        .re_b(re_b), .raddr_b(raddr_b), .rdata_b(rdata_b),
        .clr(clr), .busy(busy), .done(done)
    );

    reg_bank #(.WIDTH(8), .DEPTH(5)) dut5 (
        .clk(clk), .rst_n(rst_n),
        .we(we5), .waddr(waddr5), .wdata(wdata5),
        .re_a(re_a5), .raddr_a(raddr_a5), .rdata_a(rdata_a5),
        .re_b(re_b5), .raddr_b(raddr_b5), .rdata_b(rdata_b5),
        .clr(clr5), .busy(busy5), .done(done5)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

`ifdef REG_BANK_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        we = 0; waddr = 0; wdata = 0; re_a = 0; raddr_a = 0; re_b = 0; raddr_b = 0; clr = 0;
        we5 = 0; waddr5 = 0; wdata5 = 0; re_a5 = 0; raddr_a5 = 0; re_b5 = 0; raddr_b5 = 0; clr5 = 0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        #12;
        rst_n = 1'b1;
        tick();
    endtask

    task automatic wait_done(input string nm);
        int n = 0;
        while (!done && n < 40) begin
            tick();
            n++;
        end
        chk(nm, done, 1);
    endtask

    // ---------------- reference model (DEPTH=8 instance) ----------------
    int          m_mem [8];
    bit          m_busy;
    int          m_idx;
    bit          m_done;
    logic [15:0] m_ra, m_rb;

    task automatic m_reset();
        foreach (m_mem[i]) m_mem[i] = 0;
        m_busy = 0; m_idx = 0; m_done = 0; m_ra = 0; m_rb = 0;
    endtask

    function automatic logic [15:0] m_read(input int a);
        if (BYP && !m_busy && we && a == int'(waddr)) return wdata;
        if (BYP && m_busy && a == m_idx) return 16'h0;
        return 16'(m_mem[a]);
    endfunction

    // Advance the model across one clock edge using the current inputs.
    task automatic m_step();
        logic [15:0] na, nb;
        na = re_a ? m_read(int'(raddr_a)) : m_ra;
        nb = re_b ? m_read(int'(raddr_b)) : m_rb;
        m_ra = na;
        m_rb = nb;
        if (m_busy) begin
            m_mem[m_idx] = 0;
            m_idx++;
            m_done = (m_idx == 8);
            if (m_done) m_busy = 0;
        end else begin
            m_done = 0;
            if (we) m_mem[int'(waddr)] = int'(wdata);
            if (clr) begin
                m_busy = 1;
                m_idx  = 0;
            end
        end
    endtask

    // ---------------- directed vector table ----------------
    typedef struct {
        logic        we;
        logic [2:0]  waddr;
        logic [15:0] wdata;
        logic        re_a;
        logic [2:0]  raddr_a;
        logic        re_b;
        logic [2:0]  raddr_b;
        logic [15:0] exp_a;
        logic [15:0] exp_b;
    } vec_t;

    vec_t vecs[$];

    task automatic add_vec(input logic w, input logic [2:0] wa, input logic [15:0] wd,
                           input logic ra, input logic [2:0] aa, input logic rb,
                           input logic [2:0] ab, input logic [15:0] ea, input logic [15:0] eb);
        vec_t v;
        v.we = w; v.waddr = wa; v.wdata = wd; v.re_a = ra; v.raddr_a = aa;
        v.re_b = rb; v.raddr_b = ab; v.exp_a = ea; v.exp_b = eb;
        vecs.push_back(v);
    endtask

    initial begin
        logic [15:0] coll_exp;
        logic [15:0] exp_b0;
        int cnt;

        idle_inputs();
        rst_n = 1'b0;
        #12;
        chk("reset_busy", busy, 0);
        chk("reset_done", done, 0);
        chk("reset_rdata_a", rdata_a, 0);
        chk("reset_rdata_b", rdata_b, 0);
        rst_n = 1'b1;
        tick();

        for (int i = 0; i < 8; i++) begin
            re_a = 1; raddr_a = 3'(i); re_b = 1; raddr_b = 3'(7 - i);
            tick();
            chk("reset_read_a", rdata_a, 0);
            chk("reset_read_b", rdata_b, 0);
        end
        idle_inputs();

        coll_exp = BYP ? 16'hBEEF : 16'h1005;
        add_vec(1, 3, 16'hA5A5, 0, 0, 0, 0, 16'h0000, 16'h0000);
        add_vec(0, 0, 16'h0000, 1, 3, 0, 0, 16'hA5A5, 16'h0000);
        add_vec(0, 0, 16'h0000, 0, 3, 0, 0, 16'hA5A5, 16'h0000);
        for (int i = 0; i < 8; i++)
            add_vec(1, 3'(i), 16'h1000 + 16'(i), 0, 0, 0, 0, 16'hA5A5, 16'h0000);
        add_vec(0, 0, 16'h0000, 1, 2, 1, 7, 16'h1002, 16'h1007);
        add_vec(0, 0, 16'h0000, 1, 4, 1, 4, 16'h1004, 16'h1004);
        add_vec(1, 5, 16'hBEEF, 1, 5, 0, 0, coll_exp, 16'h1004);
        add_vec(0, 0, 16'h0000, 1, 5, 1, 5, 16'hBEEF, 16'hBEEF);
        add_vec(0, 0, 16'h0000, 1, 3, 0, 0, 16'h1003, 16'hBEEF);

        foreach (vecs[i]) begin
            we = vecs[i].we; waddr = vecs[i].waddr; wdata = vecs[i].wdata;
            re_a = vecs[i].re_a; raddr_a = vecs[i].raddr_a;
            re_b = vecs[i].re_b; raddr_b = vecs[i].raddr_b;
            tick();
            chk($sformatf("vec%0d_rdata_a", i), rdata_a, vecs[i].exp_a);
            chk($sformatf("vec%0d_rdata_b", i), rdata_b, vecs[i].exp_b);
            chk($sformatf("vec%0d_busy", i), busy, 0);
        end
        idle_inputs();

        // ---- clear sweep: busy length, reads during sweep, dropped write, ignored clr
        clr = 1;
        tick();
        clr = 0;
        chk("clr_busy_start", busy, 1);
        chk("clr_done_start", done, 0);
        cnt = 1;
        exp_b0 = BYP ? 16'h0000 : 16'h1000;
        for (int k = 0; k < 20; k++) begin
            idle_inputs();
            if (k == 0) begin
                re_a = 1; raddr_a = 7; re_b = 1; raddr_b = 0;
            end
            if (k == 3) begin
                we = 1; waddr = 1; wdata = 16'hDEAD; clr = 1;
            end
            tick();
            if (k == 0) begin
                chk("sweep_read_unswept", rdata_a, 16'h1007);
                chk("sweep_read_at_ptr", rdata_b, exp_b0);
            end
            if (!busy) break;
            cnt++;
        end
        idle_inputs();
        chk("clr_busy_cycles", cnt, 8);
        chk("clr_done_pulse", done, 1);
        tick();
        chk("clr_done_one_cycle", done, 0);
        for (int i = 0; i < 8; i++) begin
            re_a = 1; raddr_a = 3'(i); re_b = 1; raddr_b = 3'(7 - i);
            tick();
            chk("after_clr_a", rdata_a, 0);
            chk("after_clr_b", rdata_b, 0);
        end
        idle_inputs();

        // ---- clr + we same cycle; new clr in the done cycle
        we = 1; waddr = 6; wdata = 16'h1234; clr = 1;
        tick();
        idle_inputs();
        re_a = 1; raddr_a = 6;
        tick();
        chk("clr_we_written", rdata_a, 16'h1234);
        wait_done("clr_we_done");
        clr = 1;
        tick();
        clr = 0;
        chk("clr_in_done_cycle", busy, 1);
        wait_done("second_sweep_done");
        idle_inputs();
        re_a = 1; raddr_a = 6;
        tick();
        chk("clr_we_swept", rdata_a, 0);
        idle_inputs();

        // ---- reset mid-sweep
        we = 1; waddr = 6; wdata = 16'h6666;
        tick();
        idle_inputs();
        clr = 1;
        tick();
        clr = 0;
        tick(); tick(); tick();
        chk("midsweep_busy_before", busy, 1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("midsweep_busy_reset", busy, 0);
        chk("midsweep_done_reset", done, 0);
        #10;
        rst_n = 1'b1;
        tick();
        cnt = 0;
        for (int k = 0; k < 12; k++) begin
            if (done) cnt++;
            tick();
        end
        chk("midsweep_no_done", cnt, 0);
        for (int i = 0; i < 8; i++) begin
            re_a = 1; raddr_a = 3'(i);
            tick();
            chk("midsweep_zero", rdata_a, 0);
        end
        idle_inputs();
        we = 1; waddr = 4; wdata = 16'h4444;
        tick();
        idle_inputs();
        re_b = 1; raddr_b = 4;
        tick();
        chk("after_reset_rw", rdata_b, 16'h4444);
        idle_inputs();

        // ---- DEPTH=5 instance
        we5 = 1; waddr5 = 6; wdata5 = 8'h66;
        tick();
        we5 = 1; waddr5 = 2; wdata5 = 8'h22;
        tick();
        we5 = 0;
        re_a5 = 1; raddr_a5 = 6;
        tick();
        chk("d5_oor_read", rdata_a5, 0);
        for (int i = 0; i < 5; i++) begin
            re_b5 = 1; raddr_b5 = 3'(i);
            tick();
            chk("d5_entries", rdata_b5, (i == 2) ? 8'h22 : 8'h00);
        end
        idle_inputs();
        clr5 = 1;
        tick();
        clr5 = 0;
        cnt = 0;
        for (int k = 0; k < 20; k++) begin
            if (!busy5) break;
            cnt++;
            tick();
        end
        chk("d5_busy_cycles", cnt, 5);
        chk("d5_done", done5, 1);
        re_a5 = 1; raddr_a5 = 2;
        tick();
        chk("d5_cleared", rdata_a5, 0);
        idle_inputs();

        // ---- randomized phase against the reference model
        do_reset();
        m_reset();
        for (int c = 0; c < 500; c++) begin
            we      = 1'($urandom_range(0, 1));
            waddr   = 3'($urandom_range(0, 7));
            wdata   = 16'($urandom);
            re_a    = 1'($urandom_range(0, 1));
            raddr_a = 3'($urandom_range(0, 7));
            re_b    = 1'($urandom_range(0, 1));
            raddr_b = 3'($urandom_range(0, 7));
            clr     = ($urandom_range(0, 19) == 0);
            m_step();
            tick();
            chk("rand_rdata_a", rdata_a, m_ra);
            chk("rand_rdata_b", rdata_b, m_rb);
            chk("rand_busy", busy, m_busy);
            chk("rand_done", done, m_done);
        end
        idle_inputs();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/reg_bank.md
# reg_bank

Parametrised bank of `DEPTH` registers, each `WIDTH` bits wide. It has one write port, two independent registered read ports, and a sequenced clear-all engine. It replaces single-register instances wherever the datapath needs several addressable storage words, such as operand/accumulator files, without a separate clear mux per word.

## Interface
- `WIDTH`, 16, bits per entry (≥1)
- `DEPTH`, 8, number of entries (≥2; need not be a power of two)
- `AW`, derived as $clog2(DEPTH), address width; not overridable
- `clk`  in  1  clock; all state updates on rising edge
- `rst_n`  in  1  reset, asynchronous, active-low; one clock domain only
- `we`  in  1  write enable
- `waddr`  in  AW  write address
- `wdata`  in  WIDTH  write data
- `re_a`  in  1  read enable, port A
- `raddr_a`  in  AW  read address, port A
- `rdata_a`  out  WIDTH  registered read data, port A
- `re_b`  in  1  read enable, port B
- `raddr_b`  in  AW  read address, port B
- `rdata_b`  out  WIDTH  registered read data, port B
- `clr`  in  1  request to clear all entries (sampled level; a 1-cycle pulse is sufficient)
- `busy`  out  1  clear sweep in progress
- `done`  out  1  one-cycle pulse when the sweep completes

## Operation
- Reset (`rst_n`=0, asynchronous):
  - all entries = 0
  - `rdata_a` = `rdata_b` = 0
  - `busy` = `done` = 0
  - FSM = IDLE, sweep pointer = 0
- Write: at the edge with `we`=1, FSM in IDLE and `waddr` < `DEPTH`, entry[`waddr`] ← `wdata`. Otherwise no entry changes.
  - `waddr` ≥ `DEPTH` → write silently dropped.
- Read, per port independently:
  - at the edge with `re_x`=1, `rdata_x` ← entry[`raddr_x`]
  - out-of-range address → `rdata_x` ← 0
  - `re_x`=0 → `rdata_x` holds its previous value
  - reads are permitted in every FSM state
- Both ports may read the same address in the same cycle; both return the same value.
- FSM has two states, IDLE and CLEAR:
  - IDLE → CLEAR on `clr`=1; sweep pointer ← 0
  - CLEAR: each cycle, entry[pointer] ← 0 and pointer increments
  - CLEAR → IDLE after the entry at `DEPTH`-1 is cleared; `done` pulses for one cycle
- `busy` = 1 exactly while the FSM is in CLEAR.
- `we` asserted while `busy`=1 → write dropped (no queuing); `clr` asserted while `busy`=1 → ignored.
- `clr` and `we` in the same IDLE cycle → the write is performed, then swept. The entry ends at 0.
- Read of entry k during CLEAR:
  - returns the old value if pointer ≤ k at the sampling edge
  - returns 0 once that entry has been swept
- Reset asserted mid-sweep → immediate return to IDLE with all entries 0; no `done` pulse.

## Timing
- Write-to-storage latency: 1 cycle; the entry is updated at the edge where `we` is sampled.
- Read latency: 1 cycle; `rdata_x` is valid after the edge where `re_x` is sampled.
- Same-cycle write and read of the same address: see Configuration.
- Clear sequence, with `clr` sampled at edge E0:
  - `busy` = 1 from after E0 through E_DEPTH
  - entry k is zeroed at edge E(k+1)
  - after E_DEPTH: `busy` = 0 and `done` = 1 for exactly one cycle
  - a new `clr` is accepted in that `done` cycle
- Throughput: one write and two reads per cycle in IDLE; the full clear takes `DEPTH` cycles of `busy`.

## Configuration
- `REG_BANK_BYPASS_EN` defined:
  - a read whose address matches an accepted write in the same cycle returns `wdata`
  - a read of the entry being swept in that cycle returns 0
  - i.e. write-first semantics
- Not defined: such a read returns the pre-write / pre-sweep content (read-first semantics). No forwarding logic is instantiated.

## Test plan
- Reset and write/read with WIDTH=16, DEPTH=8:
  - after reset, reading addresses 0..7 returns 0
  - write 0xA5A5 to addr 3; one cycle later, `re_a`=1 with `raddr_a`=3 → `rdata_a`=0xA5A5 one cycle after
  - `re_a`=0 → `rdata_a` holds 0xA5A5
- Dual read: fill entry i with 0x1000+i; read A addr 2 and B addr 7 in the same cycle → 0x1002 and 0x1007; same address on both ports → identical data.
- Collision, write 0xBEEF to addr 5 with a same-cycle read of addr 5 (old value 0x1005):
  - with the macro → 0xBEEF
  - without the macro → 0x1005
  - next read → 0xBEEF in both builds
- Clear sweep:
  - pulse `clr` → `busy` high for exactly 8 cycles, then `done` high for 1 cycle
  - `we` to addr 1 during `busy` is dropped
  - all entries read 0 afterwards
  - `clr` and `we` (addr 6, 0x1234) in the same cycle → entry 6 = 0 at the end
- Reset mid-sweep: deassert `rst_n` 3 cycles into CLEAR → `busy`=0 immediately, no `done`, all entries 0. A subsequent write/read works normally.
- Non-power-of-two, DEPTH=5:
  - write to addr 6 → dropped
  - read of addr 6 → 0
  - `clr` → `busy` for 5 cycles
